// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 icode/ifun/register constants and condition-code bit positions
package y86_pkg;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_XOR  = 4'h3;
  localparam logic [3:0] C_YES    = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;
  localparam logic [3:0] RNONE    = 4'hF;
  localparam int ZF_B = 2;
  localparam int SF_B = 1;
  localparam int OF_B = 0;
  typedef enum logic [3:0] {
    COND_YES = 4'h0,
    COND_LE  = 4'h1,
    COND_L   = 4'h2,
    COND_E   = 4'h3,
    COND_NE  = 4'h4,
    COND_GE  = 4'h5,
    COND_G   = 4'h6
  } cond_e;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: jump/cmov condition from {ZF,SF,OF} (cc_i) and ifun (ifun_i) to cnd_o
module cond_eval
  import y86_pkg::*;
(
  input  logic [2:0] cc_i,
  input  logic [3:0] ifun_i,
  output logic       cnd_o
);
  logic zf, lt;
  always_comb begin
    zf = cc_i[ZF_B];
    lt = cc_i[SF_B] ^ cc_i[OF_B];
    cnd_o = ifun_i == C_YES ? 1'b1 :
            ifun_i == C_LE  ? lt | zf :
            ifun_i == C_L   ? lt :
            ifun_i == C_E   ? zf :
            ifun_i == C_NE  ? !zf :
            ifun_i == C_GE  ? !lt :
            ifun_i == C_G   ? !lt && !zf : 1'b0;
  end
endmodule

// File: rtl/exec_cc_stage.sv
// exec_cc_stage: Y86-64 execute back end (flags, CC register, cond eval, E->M valid/ready register); `CC_STATS_EN adds cc_upd_cnt
module exec_cc_stage
  import y86_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_icode,
  input  logic [3:0]       in_ifun,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_e,
  input  logic [WIDTH-1:0] in_valA,
  input  logic [3:0]       in_dstE,
  input  logic [3:0]       in_dstM,
  input  logic             exc_mw,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_valE,
  output logic [WIDTH-1:0] out_valA,
  output logic [3:0]       out_dstE,
  output logic [3:0]       out_dstM,
  output logic [3:0]       out_icode,
  output logic             out_cnd,
  output logic [2:0]       cc
`ifdef CC_STATS_EN
  ,
  output logic [31:0]      cc_upd_cnt
`endif
);
  localparam int M = WIDTH - 1;
  logic             valid_q;
  logic [WIDTH-1:0] val_e_q, val_a_q;
  logic [3:0]       dst_e_q, dst_m_q, icode_q;
  logic             cnd_q;
  logic [2:0]       cc_q, cc_d;
  logic [3:0]       dst_e_d;
  logic             acc, cc_wr, cnd_raw, cnd_d, of;
  logic             unused_ab;
  cond_eval u_cond (
    .cc_i   (cc_q),
    .ifun_i (in_ifun),
    .cnd_o  (cnd_raw)
  );
  assign unused_ab = ^{alu_a[M-1:0], alu_b[M-1:0]};
  always_comb begin
    in_ready = !valid_q || out_ready;
    acc      = in_valid && in_ready;
    cc_wr    = acc && in_icode == I_OPQ && !exc_mw;
    of = in_ifun == ALU_ADD ? alu_a[M] == alu_b[M] && alu_e[M] != alu_a[M] :
         in_ifun == ALU_SUB ? alu_a[M] != alu_b[M] && alu_e[M] != alu_b[M] : 1'b0;
    cc_d    = {alu_e == '0, alu_e[M], of};
    cnd_d   = (in_icode == I_JXX || in_icode == I_CMOVXX) ? cnd_raw : 1'b0;
    dst_e_d = (in_icode == I_CMOVXX && !cnd_raw) ? RNONE : in_dstE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      val_e_q <= '0;
      val_a_q <= '0;
      dst_e_q <= RNONE;
      dst_m_q <= RNONE;
      icode_q <= 4'h0;
      cnd_q   <= 1'b0;
      cc_q    <= 3'b100;
    end else begin
      if (acc) begin
        valid_q <= 1'b1;
        val_e_q <= alu_e;
        val_a_q <= in_valA;
        dst_e_q <= dst_e_d;
        dst_m_q <= in_dstM;
        icode_q <= in_icode;
        cnd_q   <= cnd_d;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
      if (cc_wr) cc_q <= cc_d;
    end
  end
`ifdef CC_STATS_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (cc_wr) cnt_q <= cnt_q + 32'd1;
  end
  assign cc_upd_cnt = cnt_q;
`endif
  assign out_valid = valid_q;
  assign out_valE  = val_e_q;
  assign out_valA  = val_a_q;
  assign out_dstE  = dst_e_q;
  assign out_dstM  = dst_m_q;
  assign out_icode = icode_q;
  assign out_cnd   = cnd_q;
  assign cc        = cc_q;
endmodule

// File: tb/tb_exec_cc_stage.sv
// tb_exec_cc_stage: randomized + directed check of exec_cc_stage against a behavioural model
module tb_exec_cc_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, exc_mw, out_valid, out_ready, out_cnd;
  logic [3:0]  in_icode, in_ifun, in_dstE, in_dstM, out_dstE, out_dstM, out_icode;
  logic [63:0] alu_a, alu_b, alu_e, in_valA, out_valE, out_valA;
  logic [2:0]  cc;
`ifdef CC_STATS_EN
  logic [31:0] cc_upd_cnt;
`endif
  int n_tests = 0, n_fail = 0;
  logic        m_valid, m_cnd;
  logic [2:0]  m_cc;
  logic [63:0] m_valE, m_valA;
  logic [3:0]  m_dstE, m_dstM, m_icode;
  logic [31:0] m_cnt;
  always #5 clk = ~clk;
  exec_cc_stage #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_icode(in_icode), .in_ifun(in_ifun), .alu_a(alu_a), .alu_b(alu_b),
    .alu_e(alu_e), .in_valA(in_valA), .in_dstE(in_dstE), .in_dstM(in_dstM),
    .exc_mw(exc_mw), .out_valid(out_valid), .out_ready(out_ready),
    .out_valE(out_valE), .out_valA(out_valA), .out_dstE(out_dstE),
    .out_dstM(out_dstM), .out_icode(out_icode), .out_cnd(out_cnd), .cc(cc)
`ifdef CC_STATS_EN
    , .cc_upd_cnt(cc_upd_cnt)
`endif
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic cond(input logic [2:0] c, input logic [3:0] f);
    logic zf, lt;
    zf = c[2];
    lt = c[1] != c[0];
    case (f)
      4'd0: return 1'b1;
      4'd1: return lt || zf;
      4'd2: return lt;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return !lt;
      4'd6: return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction
  function automatic logic [2:0] flags(input logic [3:0] f, input logic [63:0] a, b, e);
    logic signed [64:0] s;
    logic of;
    of = 1'b0;
    if (f == 4'd0) begin
      s = $signed({a[63], a}) + $signed({b[63], b});
      of = s[64] != s[63];
    end else if (f == 4'd1) begin
      s = $signed({b[63], b}) - $signed({a[63], a});
      of = s[64] != s[63];
    end
    return {e == 64'd0, e[63], of};
  endfunction
  task automatic check_outs();
    check("out_valid", out_valid, m_valid);
    check("cc", cc, m_cc);
`ifdef CC_STATS_EN
    check("cc_upd_cnt", cc_upd_cnt, m_cnt);
`endif
    if (m_valid) begin
      check("out_valE", out_valE, m_valE);
      check("out_valA", out_valA, m_valA);
      check("out_dstE", out_dstE, m_dstE);
      check("out_dstM", out_dstM, m_dstM);
      check("out_icode", out_icode, m_icode);
      check("out_cnd", out_cnd, m_cnd);
    end
  endtask
  task automatic cyc(input logic v, input logic [3:0] ic, f, input logic [63:0] a, b, e, va,
                     input logic [3:0] de, dm, input logic x, r);
    logic acc, c;
    rst = 1'b0; in_valid = v; in_icode = ic; in_ifun = f; alu_a = a; alu_b = b; alu_e = e;
    in_valA = va; in_dstE = de; in_dstM = dm; exc_mw = x; out_ready = r;
    #1;
    check("in_ready", in_ready, !m_valid || r);
    acc = v && (!m_valid || r);
    if (acc) begin
      c = cond(m_cc, f);
      m_cnd = (ic == 4'd2 || ic == 4'd7) ? c : 1'b0;
      m_dstE = (ic == 4'd2 && !c) ? 4'hF : de;
      m_valE = e; m_valA = va; m_dstM = dm; m_icode = ic; m_valid = 1'b1;
    end else if (r) m_valid = 1'b0;
    if (acc && ic == 4'd6 && !x) begin
      m_cc = flags(f, a, b, e);
      m_cnt = m_cnt + 32'd1;
    end
    @(posedge clk);
    @(negedge clk);
    check_outs();
  endtask
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b1; in_icode = 4'd6; in_ifun = 4'd0; alu_a = 64'd1; alu_b = 64'd1;
    alu_e = 64'd2; in_valA = 64'd9; in_dstE = 4'd1; in_dstM = 4'd2; exc_mw = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cc", cc, 3'b100);
    check("rst_valid", out_valid, 1'b0);
    check("rst_dstE", out_dstE, 4'hF);
    check("rst_dstM", out_dstM, 4'hF);
    check("rst_valE", out_valE, 64'd0);
    check("rst_valA", out_valA, 64'd0);
    check("rst_icode", out_icode, 4'd0);
    check("rst_cnd", out_cnd, 1'b0);
`ifdef CC_STATS_EN
    check("rst_cnt", cc_upd_cnt, 32'd0);
`endif
    m_valid = 1'b0; m_cc = 3'b100; m_valE = '0; m_valA = '0; m_dstE = 4'hF; m_dstM = 4'hF;
    m_icode = 4'd0; m_cnd = 1'b0; m_cnt = 32'd0;
  endtask
  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_FFFF_FFFF;
      4: return 64'($urandom_range(0, 7));
      default: return {$urandom, $urandom};
    endcase
  endfunction
  initial begin
    do_reset();
    cyc(1, 6, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 64'd7, 4'd1, 4'hF, 0, 1);
    check("addof_cc", cc, 3'b011);
    check("addof_valE", out_valE, 64'h8000_0000_0000_0000);
    check("addof_valid", out_valid, 1'b1);
    cyc(1, 6, 1, 64'd5, 64'd5, 64'd0, 64'd0, 4'd2, 4'hF, 0, 1);
    check("subz_cc", cc, 3'b100);
    cyc(1, 2, 3, 64'd0, 64'd0, 64'd0, 64'd11, 4'd3, 4'hF, 0, 1);
    check("cmove_cnd", out_cnd, 1'b1);
    check("cmove_dstE", out_dstE, 4'd3);
    cyc(1, 2, 4, 64'd0, 64'd0, 64'd0, 64'd11, 4'd3, 4'hF, 0, 1);
    check("cmovne_cnd", out_cnd, 1'b0);
    check("cmovne_dstE", out_dstE, 4'hF);
    cyc(1, 6, 2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
        64'h1234, 4'd5, 4'd6, 1, 1);
    check("exc_cc", cc, 3'b100);
    check("exc_valE", out_valE, 64'h8000_0000_0000_0000);
    check("exc_valA", out_valA, 64'h1234);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 6, 0, 64'd1, 64'd2, 64'd3, 64'd4, 4'd7, 4'd8, 0, 0);
      check("bp_ready", in_ready, 1'b0);
      check("bp_valE", out_valE, 64'h8000_0000_0000_0000);
      check("bp_cc", cc, 3'b100);
    end
    cyc(1, 6, 0, 64'd1, 64'd2, 64'd3, 64'd4, 4'd7, 4'd8, 0, 1);
    check("bp_go_cc", cc, 3'b000);
    check("bp_go_valE", out_valE, 64'd3);
`ifdef CC_STATS_EN
    check("cnt3", cc_upd_cnt, 32'd3);
`endif
    cyc(0, 0, 0, 64'd0, 64'd0, 64'd0, 64'd0, 4'd0, 4'd0, 0, 1);
    check("drain_valid", out_valid, 1'b0);
    check("drain_cc", cc, 3'b000);
    cyc(1, 7, 7, 64'd0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 0, 1);
    check("jxx7_cnd", out_cnd, 1'b0);
    cyc(1, 7, 0, 64'd0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 0, 1);
    check("jmp_cnd", out_cnd, 1'b1);
    cyc(1, 3, 0, 64'd0, 64'd0, 64'd42, 64'd0, 4'd4, 4'hF, 0, 1);
    check("irmov_cnd", out_cnd, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      logic [3:0]  ic, f;
      logic [63:0] a, b, e;
      int sel;
      sel = $urandom_range(0, 9);
      ic = sel < 4 ? 4'd6 : sel < 6 ? 4'd2 : sel < 8 ? 4'd7 : 4'($urandom_range(0, 15));
      f = (ic == 4'd6 && $urandom_range(0, 7) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      a = rnd64();
      b = $urandom_range(0, 3) == 0 ? a : rnd64();
      case (f)
        4'd0: e = a + b;
        4'd1: e = b - a;
        4'd2: e = a & b;
        4'd3: e = a ^ b;
        default: e = rnd64();
      endcase
      if (ic != 4'd6) e = rnd64();
      cyc($urandom_range(0, 3) != 0, ic, f, a, b, e, {$urandom, $urandom},
          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0);
    end
    do_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/exec_cc_stage.md
Name: exec_cc_stage

Overview:
- Execute-stage back end of the Y86-64 pipeline. Sits directly downstream of the combinational ALU (add/sub/and/xor slices).
- Derives ZF/SF/OF from the ALU operands and result, and holds the condition-code register.
- Evaluates jump/cmov conditions and registers the E→M pipeline payload behind a valid/ready handshake.

Parameters:
- WIDTH, 64, datapath width of operands, result and valA.
- RNONE, 4'hF, register ID meaning "no destination".

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept: !out_valid || out_ready (combinational).
- in_icode  in  4  instruction code; OPq=6, CMOVXX=2, JXX=7.
- in_ifun  in  4  function code (ALU op or condition).
- alu_a  in  WIDTH  ALU operand A (aluA).
- alu_b  in  WIDTH  ALU operand B (aluB).
- alu_e  in  WIDTH  ALU result (valE) from the upstream ALU.
- in_valA  in  WIDTH  pass-through valA.
- in_dstE  in  4  destination for valE.
- in_dstM  in  4  destination for valM.
- exc_mw  in  1  exception present in M or W stage; suppresses CC update.
- out_valid  out  1  payload valid.
- out_ready  in  1  downstream accepts.
- out_valE  out  WIDTH  registered alu_e.
- out_valA  out  WIDTH  registered in_valA.
- out_dstE  out  4  registered dstE, after cmov squash.
- out_dstM  out  4  registered dstM.
- out_icode  out  4  registered icode.
- out_cnd  out  1  registered condition result.
- cc  out  3  current {ZF,SF,OF}.

Behaviour:
- Reset (rst=1 at edge):
  - cc=3'b100 (ZF=1).
  - out_valid=0; out_valE, out_valA, out_icode, out_cnd = 0.
  - out_dstE=RNONE, out_dstM=RNONE.
  - Reset wins over any simultaneous transfer.
- Accept = in_valid && in_ready.
- On accept, the output register loads the payload in one cycle (latency 1) and out_valid=1.
- If out_valid && out_ready && !in_valid, out_valid clears at the edge.
- While out_valid && !out_ready, all outputs hold stable.
- Flags (combinational, from alu_a/alu_b/alu_e; MSB = WIDTH-1):
  - ZF = (alu_e==0); SF = alu_e[MSB].
  - OF for add (ifun 0): a[MSB]==b[MSB] && e[MSB]!=a[MSB].
  - OF for sub (ifun 1, e=b-a): a[MSB]!=b[MSB] && e[MSB]!=b[MSB].
  - OF for and/xor: 0.
- CC write at the edge only when accept && in_icode==OPq && !exc_mw.
  - Otherwise cc holds, including when OPq is stalled or exc_mw=1.
- Condition evaluation uses the current cc (pre-update value):
  - ifun 0: 1.
  - ifun 1: (SF^OF)|ZF.
  - ifun 2: SF^OF.
  - ifun 3: ZF.
  - ifun 4: !ZF.
  - ifun 5: !(SF^OF).
  - ifun 6: !(SF^OF)&&!ZF.
  - ifun 7–15: 0.
  - An instruction accepted the cycle after an OPq acceptance sees the updated cc.
- out_cnd = evaluated condition for JXX/CMOVXX, 0 for all other icodes.
- out_dstE = RNONE when icode==CMOVXX and the condition is 0; else in_dstE.
- WIDTH arithmetic is unsigned bit-level; no extension or truncation.

Optional Feature:
- CC_STATS_EN defined: adds output port cc_upd_cnt (32 bits), reset 0, incremented on every CC write, wraps 0xFFFFFFFF→0.
- CC_STATS_EN undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: I_OPQ, I_CMOVXX, I_JXX.
  - ALU ifun constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR.
  - Condition ifun constants: C_YES..C_G.
  - RNONE.
  - cc bit indices ZF_B, SF_B, OF_B.
- One sub-module: cond_eval (combinational: cc + ifun → cnd), reusable by fetch-stage branch logic.

Test Plan:
- Reset:
  - Stimulus: rst=1 two cycles.
  - Required: cc=3'b100, out_valid=0, out_dstE=out_dstM=4'hF.
- OPq add overflow:
  - Stimulus: a=0x7FFF_FFFF_FFFF_FFFF, b=1, e=0x8000_0000_0000_0000, out_ready=1.
  - Required: next cycle cc=3'b011, out_valE=e, out_valid=1.
- Sub zero then cmove:
  - Stimulus: OPq ifun1 a=b=5, e=0 → cc=3'b100; next CMOVXX ifun3 dstE=3.
  - Required: out_cnd=1, out_dstE=3.
  - Stimulus: CMOVXX ifun4 dstE=3.
  - Required: out_cnd=0, out_dstE=4'hF.
- Exception suppression:
  - Stimulus: cc=3'b100; OPq and with e=0x8000_0000_0000_0000, exc_mw=1.
  - Required: cc stays 3'b100; payload still registered.
- Backpressure:
  - Stimulus: out_ready=0 with out_valid=1; in_valid=1 with OPq for 3 cycles.
  - Required: in_ready=0, outputs and cc unchanged.
  - Stimulus: out_ready=1.
  - Required: accept in that cycle, cc updates once.
- JXX ifun 7 and non-branch icode:
  - Required: out_cnd=0.
  - With CC_STATS_EN: after 3 CC writes, cc_upd_cnt=3.
